uart_byte_fifo: RTL and testbench

Byte buffer between the UART receiver and the UART transmitter in the echo path. It captures each received byte on the rising edge of the receiver's ready strobe, stores up to DEPTH bytes, and replays them to the transmitter one at a time. Replay uses the transmitter's start/done handshake, so back-to-back received bytes are no longer lost while the transmitter is busy.

---
 rtl/uart_byte_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_byte_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the UART receiver and transmitter; replays bytes over a start/done handshake.
// Define UART_FIFO_OVF_CNT_EN to add the saturating ovf_cnt output.
module uart_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_word,
  input  logic        in_valid,
  input  logic        hold,
  input  logic        tx_done,
  output logic [7:0]  tx_word,
  output logic        tx_start,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full,
  output logic        overflow
`ifdef UART_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]  ovf_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic          in_valid_q_r;
  logic          tx_done_q_r;
  logic          wr_evt_s;
  logic          done_evt_s;
  logic          pop_s;
  logic          wr_drop_s;
  logic          wr_acc_s;
  logic [AW:0]   count_nxt_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [7:0]    mem_r [DEPTH];
  state_t        state_r;
  state_t        state_nxt_s;
  logic          tx_start_nxt_s;
  logic          load_s;

  // Edge-detect history; reset high so a level already present at release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q_r <= 1'b1;
      tx_done_q_r  <= 1'b1;
    end else begin
      in_valid_q_r <= in_valid;
      tx_done_q_r  <= tx_done;
    end
  end

  // Write/pop events; a write into a full FIFO survives only if a pop frees a slot on the same edge.
  always_comb begin
    wr_evt_s   = in_valid & ~in_valid_q_r;
    done_evt_s = tx_done & ~tx_done_q_r;
    pop_s      = done_evt_s & (state_r == ST_SEND);
    wr_drop_s  = wr_evt_s & full & ~pop_s;
    wr_acc_s   = wr_evt_s & ~wr_drop_s;
    case ({wr_acc_s, pop_s})
      2'b10:   count_nxt_s = count + CNT_ONE;
      2'b01:   count_nxt_s = count - CNT_ONE;
      default: count_nxt_s = count;
    endcase
  end

  // Byte storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= in_word;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy flags come from the count, not pointer equality.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count    <= {(AW+1){1'b0}};
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count    <= count_nxt_s;
      empty    <= (count_nxt_s == {(AW+1){1'b0}});
      full     <= (count_nxt_s == CNT_FULL);
      overflow <= wr_drop_s;
    end
  end

  // Replay FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; GAP waits for tx_done to fall so a held done cannot complete the next byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty && !hold) state_nxt_s = ST_LOAD;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_SEND;
      ST_SEND: begin
        if (done_evt_s) state_nxt_s = ST_GAP;
        else            state_nxt_s = ST_SEND;
      end
      ST_GAP: begin
        if (!tx_done) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode, registered below so tx_start is glitch-free.
  always_comb begin
    tx_start_nxt_s = (state_nxt_s == ST_SEND);
    load_s         = (state_r == ST_LOAD);
  end

  // Transmitter-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_word  <= 8'h00;
    end else begin
      tx_start <= tx_start_nxt_s;
      if (load_s) tx_word <= mem_r[rd_ptr_r];
    end
  end

`ifdef UART_FIFO_OVF_CNT_EN
  // Saturating count of dropped bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= 8'h00;
    end else if (wr_drop_s && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_byte_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_word;
  logic       in_valid;
  logic       hold;
  logic       tx_done;
  logic [7:0] tx_word;
  logic       tx_start;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
`ifdef UART_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] model_q[$];
  logic       prev_v;
  logic       prev_d;
  int         exp_ovfc;
  int         vlen;
  int         dlen;
  int         n0;

  uart_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_word  (in_word),
    .in_valid (in_valid),
    .hold     (hold),
    .tx_done  (tx_done),
    .tx_word  (tx_word),
    .tx_start (tx_start),
    .count    (count),
    .empty    (empty),
    .full     (full),
`ifdef UART_FIFO_OVF_CNT_EN
    .overflow (overflow),
    .ovf_cnt  (ovf_cnt)
`else
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    prev_v   = 1'b1;
    prev_d   = 1'b1;
    exp_ovfc = 0;
  endtask

  // One clock: called at a negedge, drives inputs, updates the model at the posedge, checks, returns at negedge.
  task automatic step(input logic v, input logic [7:0] w, input logic d, input logic h);
    logic wr, dn, seen, pop, exp_ovf;
    if (tx_start) begin
      if (model_q.size() == 0) check_val("start_empty", 32'(tx_start), 32'd0);
      else                     check_val("tx_word", 32'(tx_word), 32'(model_q[0]));
    end
    seen     = tx_start;
    in_valid = v;
    in_word  = w;
    tx_done  = d;
    hold     = h;
    wr       = v & ~prev_v;
    dn       = d & ~prev_d;
    prev_v   = v;
    prev_d   = d;
    @(posedge clk);
    pop     = dn & seen;
    exp_ovf = 1'b0;
    if (pop && model_q.size() > 0) void'(model_q.pop_front());
    if (wr) begin
      if (model_q.size() == DEPTH) begin
        exp_ovf = 1'b1;
        if (exp_ovfc < 255) exp_ovfc++;
      end else begin
        model_q.push_back(w);
      end
    end
    #1;
    check_val("count", 32'(count), 32'(model_q.size()));
    check_val("empty", 32'(empty), 32'(model_q.size() == 0));
    check_val("full", 32'(full), 32'(model_q.size() == DEPTH));
    check_val("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef UART_FIFO_OVF_CNT_EN
    check_val("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovfc));
`endif
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] w, input logic h);
    step(1'b1, w, 1'b0, h);
    step(1'b0, 8'h00, 1'b0, h);
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget && !tx_start; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("start_timeout", 32'(tx_start), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (model_q.size() == 0 && !tx_start && !tx_done) break;
      if (tx_start && !tx_done) step(1'b0, 8'h00, 1'b1, 1'b0);
      else                      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_start", 32'(tx_start), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_word  = 8'h00;
    hold     = 1'b0;
    tx_done  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int wr_pct_t[4] = '{60, 10, 85, 30};
    int tx_pct_t[4] = '{5, 70, 2, 40};
    logic v, d, h;
    logic [7:0] w;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_word  = 8'h00;
    hold     = 1'b0;
    tx_done  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_tx_word", 32'(tx_word), 32'h00);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    model_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte and start/done latency.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    check_val("lat_k", 32'(tx_start), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("lat_k1", 32'(tx_start), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("lat_k2_start", 32'(tx_start), 32'd1);
    check_val("lat_k2_word", 32'(tx_word), 32'h41);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("done_start", 32'(tx_start), 32'd0);
    check_val("done_count", 32'(count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Burst 1..5 with no completions, then in-order drain.
    for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b0);
    check_val("burst_count", 32'(count), 32'd5);
    check_val("burst_word", 32'(tx_word), 32'h01);
    drain();

    // Overflow: 17 writes, 16 kept; then wrap with 3 more.
    for (int i = 0; i < 17; i++) write_byte(8'(8'h80 + i), 1'b0);
    check_val("ovf_full", 32'(full), 32'd1);
    check_val("ovf_count", 32'(count), 32'd16);
    drain();
    for (int i = 0; i < 3; i++) write_byte(8'(8'hC0 + i), 1'b0);
    drain();

    // Simultaneous write and pop while full.
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i), 1'b0);
    wait_start(8);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check_val("sim_count", 32'(count), 32'd16);
    check_val("sim_ovf", 32'(overflow), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Hold blocks new starts; release resumes.
    write_byte(8'h21, 1'b1);
    write_byte(8'h22, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_val("hold_start", 32'(tx_start), 32'd0);
    end
    wait_start(6);

    // in_valid held high writes once; tx_done held high pops once.
    n0 = model_q.size();
    for (int i = 0; i < 10; i++) step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("level_wr", 32'(count), 32'(n0 + 1));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("level_done_start", 32'(tx_start), 32'd0);
    end
    check_val("level_done_count", 32'(count), 32'(n0));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Random traffic across load profiles.
    vlen = 0;
    dlen = 0;
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 500; c++) begin
        w = in_word;
        if (in_valid) begin
          if (vlen > 0) begin vlen--; v = 1'b1; end
          else v = 1'b0;
        end else if (int'($urandom_range(99, 0)) < wr_pct_t[seg]) begin
          v    = 1'b1;
          vlen = int'($urandom_range(2, 0));
          w    = 8'($urandom);
        end else begin
          v = 1'b0;
        end
        if (tx_done) begin
          if (dlen > 0) begin dlen--; d = 1'b1; end
          else d = 1'b0;
        end else if (tx_start && int'($urandom_range(99, 0)) < tx_pct_t[seg]) begin
          d    = 1'b1;
          dlen = int'($urandom_range(2, 0));
        end else begin
          d = 1'b0;
        end
        h = ($urandom_range(99, 0) < 3) ? ~hold : hold;
        step(v, w, d, h);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Reset in the middle of SEND with 3 bytes stored.
    for (int i = 0; i < 3; i++) write_byte(8'(8'h31 + i), 1'b0);
    wait_start(6);
`ifdef UART_FIFO_OVF_CNT_EN
    check_val("ovfc_nonzero", 32'(ovf_cnt != 8'h00), 32'd1);
`endif
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_start", 32'(tx_start), 32'd0);
    check_val("arst_count", 32'(count), 32'd0);
    check_val("arst_empty", 32'(empty), 32'd1);
`ifdef UART_FIFO_OVF_CNT_EN
    check_val("arst_ovfc", 32'(ovf_cnt), 32'd0);
`endif
    do_reset();
    write_byte(8'h5A, 1'b0);
    wait_start(6);
    check_val("post_rst_word", 32'(tx_word), 32'h5A);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
